// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, combinational ROM address, in-order fetch queue to decode.
// Optional misaligned-redirect fault detection enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [ADDRESS_WIDTH-1:0] out_pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                     fetch_fault,
  output logic [ADDRESS_WIDTH-1:0] fault_pc
`endif
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    word;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [CNT_W-1:0]         r_count;
  entry_t                   r_mem [QUEUE_DEPTH];

  logic                     w_pop;
  logic                     w_push;
  logic                     w_halted;
  logic [CNT_W-1:0]         w_count_next;
  logic [ADDRESS_WIDTH-1:0] w_redirect_target;
  entry_t                   w_head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic                     r_fault;
  logic [ADDRESS_WIDTH-1:0] r_fault_pc;

  assign w_halted          = r_fault;
  assign w_redirect_target = redirect_pc;
  assign fetch_fault       = r_fault;
  assign fault_pc          = r_fault_pc;

  // Misaligned redirect latches a sticky fault; an aligned redirect clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        r_fault    <= 1'b1;
        r_fault_pc <= redirect_pc;
      end else begin
        r_fault    <= 1'b0;
      end
    end
  end
`else
  assign w_halted          = 1'b0;
  assign w_redirect_target = redirect_pc & ~ADDRESS_WIDTH'(3);
`endif

  assign instr_addr = r_pc;
  assign w_head     = r_mem[r_rd_ptr];

  always_comb begin
    out_valid    = 1'b0;
    out_instr    = '0;
    out_pc       = '0;
    out_pc_plus4 = '0;
    w_pop        = 1'b0;
    w_push       = 1'b0;
    w_count_next = r_count;
    if (r_count != '0) begin
      out_valid    = 1'b1;
      out_instr    = w_head.word;
      out_pc       = w_head.pc;
      out_pc_plus4 = w_head.pc + ADDRESS_WIDTH'(4);
    end
    w_pop  = out_valid & out_ready;
    w_push = !redirect_valid && !w_halted && ((r_count != FULL_CNT) || w_pop);
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // PC, pointers and occupancy; redirect flushes and discards a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc     <= w_redirect_target;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + ADDRESS_WIDTH'(4);
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Queue storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= '{pc: r_pc, word: instr};
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly upstream of the combinational instruction ROM. Holds the program counter and drives the word address into instruction memory. Captures the returned instruction word together with its PC into a small in-order fetch queue, and presents it to decode over a valid/ready handshake. Control-flow redirects from execute flush the queue and reload the PC.

## Interface
- ADDRESS_WIDTH, 32, PC / instruction address width
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned
- QUEUE_DEPTH, 2, fetch queue entries; power of two, >= 2

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- instr_addr  out  ADDRESS_WIDTH  fetch address to instruction memory; always equals current PC
- instr  in  DATA_WIDTH  instruction word, combinationally returned for instr_addr in the same cycle
- redirect_valid  in  1  branch/jump taken; overrides all other activity
- redirect_pc  in  ADDRESS_WIDTH  new fetch target
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  DATA_WIDTH  head instruction; 0 when out_valid=0
- out_pc  out  ADDRESS_WIDTH  head PC; 0 when out_valid=0
- out_pc_plus4  out  ADDRESS_WIDTH  out_pc+4 modulo 2^ADDRESS_WIDTH; 0 when out_valid=0
- fetch_fault  out  1  (FETCH_ALIGN_CHECK_EN only) sticky misaligned-redirect flag
- fault_pc  out  ADDRESS_WIDTH  (FETCH_ALIGN_CHECK_EN only) offending redirect_pc

## Operation
- State: pc register, queue storage (pc, instr per entry), read/write pointers, count (0..QUEUE_DEPTH).
- pop = out_valid & out_ready.
- push = !redirect_valid & !halted & (count < QUEUE_DEPTH | pop). halted is 0 unless the FETCH_ALIGN_CHECK_EN fault is set.
- On push: the entry {pc, instr} is written at the tail, and pc <= pc + 4. The add wraps modulo 2^ADDRESS_WIDTH.
- On no push and no redirect: pc holds.
- Redirect:
  - Queue is flushed: count <= 0, pointers <= 0.
  - pc <= redirect_pc.
  - No push that cycle, and the pop in the same cycle is discarded (flush wins).
- Full queue with pop in the same cycle: push and pop both occur, and count is unchanged.
- Empty queue: out_valid=0, and out_instr, out_pc and out_pc_plus4 are all 0. There is no bypass; an entry is visible only after it is enqueued.
- Order is strictly preserved; no entry is dropped except by redirect or reset.
- Reset:
  - pc <= RESET_PC, queue empty, out_valid=0.
  - fetch_fault=0 and fault_pc=0.
  - Reset mid-operation discards all entries, and takes priority over redirect_valid.

## Timing
- instr_addr is combinational from the pc register. instr is sampled at the same edge that advances pc.
- Fetch-to-decode latency is 1 cycle: a PC fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
- After rst deasserts (first cycle with rst=0 is cycle 0):
  - Cycle 0: fetch of RESET_PC.
  - Cycle 1: out_valid=1 with out_pc=RESET_PC.
- Redirect in cycle N: out_valid=0 in cycle N+1, the fetch of redirect_pc happens in cycle N+1, and it is presented in cycle N+2.
- Steady-state throughput with out_ready=1 is one instruction per cycle.
- Backpressure: with out_ready=0, the queue fills after QUEUE_DEPTH cycles and pc then holds. Outputs are stable while out_valid=1 and out_ready=0.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault=1 and captures fault_pc=redirect_pc.
  - It flushes the queue, loads pc with the target anyway, and sets halted so no further pushes occur.
  - The fault clears only on reset or on a later redirect with an aligned target, which clears fetch_fault and halted.
  - fault_pc holds its value until the next fault or reset.
- FETCH_ALIGN_CHECK_EN undefined:
  - fetch_fault and fault_pc ports are absent.
  - redirect_pc[1:0] is ignored, and pc is loaded with {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}.

## Test plan
- Reset, RESET_PC=0, out_ready=1, ROM word k = k:
  - Cycle 1: out_pc=0, out_instr=0.
  - Cycle 2: out_pc=4, out_instr=1.
  - One new entry per cycle after that; out_pc_plus4 = out_pc+4.
- Hold out_ready=0 for 5 cycles from reset:
  - instr_addr stops at 0x8, and the head stays at out_pc=0.
  - After release, heads 0x0, 0x4, 0x8 follow consecutively with no gap or duplicate.
- redirect_valid=1, redirect_pc=0x40 while the queue is full and out_ready=1:
  - The next cycle has out_valid=0.
  - The cycle after that has out_pc=0x40, and no pre-redirect entry is ever accepted.
- Force pc to 0xFFFF_FFF8 via redirect:
  - Presented PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - out_pc_plus4 for the 0xFFFF_FFFC entry is 0.
- Assert rst for one cycle while the queue is full and a redirect is pending:
  - The next cycle has out_valid=0 and instr_addr=RESET_PC.
  - The redirect is ignored.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x42:
  - fetch_fault=1 and fault_pc=0x42, with out_valid=0 indefinitely.
  - A following redirect to 0x80 clears fetch_fault and presents out_pc=0x80 two cycles later.
- Without FETCH_ALIGN_CHECK_EN, redirect to 0x42: presented out_pc=0x40.
